// File: rtl/oam_dma_if.sv
// CPU-side snoop inputs and engine bus-initiator outputs of oam_dma_engine.
// The master modport is the engine's view and the slave modport is the surrounding top level's view.
interface oam_dma_if;
   logic        i_cpu_ce;
   logic [15:0] i_cpu_addr;
   logic        i_cpu_rnw;
   logic [7:0]  i_cpu_data;
   logic [7:0]  i_bus_data;
   logic        o_cpu_rdy;
   logic        o_bus_sel;
   logic [15:0] o_bus_addr;
   logic        o_bus_rnw;
   logic [7:0]  o_bus_data;
   logic        o_dma_active;

   modport master (
      input  i_cpu_ce, i_cpu_addr, i_cpu_rnw, i_cpu_data, i_bus_data,
      output o_cpu_rdy, o_bus_sel, o_bus_addr, o_bus_rnw, o_bus_data, o_dma_active
   );
   modport slave (
      output i_cpu_ce, i_cpu_addr, i_cpu_rnw, i_cpu_data, i_bus_data,
      input  o_cpu_rdy, o_bus_sel, o_bus_addr, o_bus_rnw, o_bus_data, o_dma_active
   );
endinterface

// File: rtl/oam_dma_engine.sv
// 256-byte page copy engine: halts the CPU, then alternates READ {page,idx} / WRITE DEST_ADDR.
// Optional macro OAM_DMA_ALIGN_EN inserts an ALIGN cycle so every READ lands on parity 0.
module oam_dma_engine #(
   parameter logic [15:0] TRIG_ADDR = 16'h4014,
   parameter logic [15:0] DEST_ADDR = 16'h2004
) (
   input  logic      i_clk,
   input  logic      i_rst,
   oam_dma_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_e;

   state_e      state_q, state_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  latch_q, latch_d;
   logic [15:0] addr_q, addr_d;
   logic        rdy_q, rdy_d;
   logic        sel_q, sel_d;
   logic        rnw_q, rnw_d;
   logic        trig;

`ifdef OAM_DMA_ALIGN_EN
   logic parity_q, parity_d;

   assign parity_d = parity_q ^ bus.i_cpu_ce;

   always_ff @(posedge i_clk) begin
      if (i_rst) parity_q <= 1'b0;
      else       parity_q <= parity_d;
   end
`endif

   // Only the CPU's own write cycles are snooped, and only from IDLE.
   assign trig = !bus.i_cpu_rnw && (bus.i_cpu_addr == TRIG_ADDR);

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      idx_d   = idx_q;
      latch_d = latch_q;
      addr_d  = addr_q;
      if (bus.i_cpu_ce) begin
         case (state_q)
            S_IDLE: if (trig) begin
               state_d = S_HALT;
               page_d  = bus.i_cpu_data;
               idx_d   = 8'h00;
            end
`ifdef OAM_DMA_ALIGN_EN
            // parity flips on this edge, so parity_q=0 means the next cycle is odd
            S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
`else
            S_HALT:  state_d = S_READ;
`endif
            S_ALIGN: state_d = S_READ;
            S_READ: begin
               latch_d = bus.i_bus_data;
               state_d = S_WRITE;
            end
            S_WRITE: begin
               if (idx_q == 8'hFF) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = S_READ;
               end
            end
            default: state_d = S_IDLE;
         endcase
         // Address register only moves when the engine owns the bus.
         if (state_d == S_READ)       addr_d = {page_d, idx_d};
         else if (state_d == S_WRITE) addr_d = DEST_ADDR;
      end
      rdy_d = (state_d == S_IDLE);
      sel_d = (state_d == S_READ) || (state_d == S_WRITE);
      rnw_d = (state_d != S_WRITE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         page_q  <= 8'h00;
         idx_q   <= 8'h00;
         latch_q <= 8'h00;
         addr_q  <= 16'h0000;
         rdy_q   <= 1'b1;
         sel_q   <= 1'b0;
         rnw_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         latch_q <= latch_d;
         addr_q  <= addr_d;
         rdy_q   <= rdy_d;
         sel_q   <= sel_d;
         rnw_q   <= rnw_d;
      end
   end

   assign bus.o_cpu_rdy    = rdy_q;
   assign bus.o_dma_active = !rdy_q;
   assign bus.o_bus_sel    = sel_q;
   assign bus.o_bus_addr   = addr_q;
   assign bus.o_bus_rnw    = rnw_q;
   assign bus.o_bus_data   = latch_q;
endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: page copies, parity alignment, page $FF, reset abort, freeze.
// A second instance with DEST_ADDR=$4014 sees its own bus cycles on the CPU snoop inputs.
module tb_oam_dma_engine;
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   oam_dma_if a_if ();
   oam_dma_if b_if ();

   logic [7:0] mem [0:65535];

   oam_dma_engine u_dut (.i_clk(i_clk), .i_rst(i_rst), .bus(a_if));
   oam_dma_engine #(.DEST_ADDR(16'h4014)) u_dut_loop (.i_clk(i_clk), .i_rst(i_rst), .bus(b_if));

   assign a_if.i_bus_data = mem[a_if.o_bus_addr];
   assign b_if.i_bus_data = mem[b_if.o_bus_addr];
   assign b_if.i_cpu_ce   = a_if.i_cpu_ce;
   assign b_if.i_cpu_addr = b_if.o_bus_sel ? b_if.o_bus_addr : a_if.i_cpu_addr;
   assign b_if.i_cpu_rnw  = b_if.o_bus_sel ? b_if.o_bus_rnw  : a_if.i_cpu_rnw;
   assign b_if.i_cpu_data = b_if.o_bus_sel ? b_if.o_bus_data : a_if.i_cpu_data;

   int   checks = 0;
   int   errors = 0;
   int   b_halt = 0;
   logic tb_par = 1'b0;
   logic s_rdy, s_sel, s_rnw, s_act;
   logic [15:0] s_addr;
   logic [7:0]  s_data;

   always @(posedge i_clk)
      if (a_if.i_cpu_ce && !i_rst && !b_if.o_cpu_rdy) b_halt <= b_halt + 1;

   function automatic logic [7:0] ramp(input logic [15:0] a);
      return a[7:0] + a[15:8];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sample();
      s_rdy  = a_if.o_cpu_rdy;
      s_sel  = a_if.o_bus_sel;
      s_addr = a_if.o_bus_addr;
      s_rnw  = a_if.o_bus_rnw;
      s_data = a_if.o_bus_data;
      s_act  = a_if.o_dma_active;
   endtask

   // One bus cycle: ce every 4th clock; outputs sampled 1ns after the closing edge.
   task automatic cyc(input logic [15:0] a, input logic rnw, input logic [7:0] d, input logic r);
      repeat (3) begin
         @(negedge i_clk);
         a_if.i_cpu_ce = 1'b0;
      end
      @(negedge i_clk);
      a_if.i_cpu_ce   = 1'b1;
      a_if.i_cpu_addr = a;
      a_if.i_cpu_rnw  = rnw;
      a_if.i_cpu_data = d;
      i_rst           = r;
      @(posedge i_clk);
      #1;
      a_if.i_cpu_ce = 1'b0;
      i_rst         = 1'b0;
      tb_par        = r ? 1'b0 : ~tb_par;
      sample();
   endtask

   task automatic run_dma(input logic [7:0] pg, input int rst_idx, input int frz_idx);
      int ncyc, nrd, nwr, bad, zacc, exp_idx, exp_cyc, b0, frz_bad, first_par;
      logic [15:0] last_rd;
      logic [27:0] snap;
      logic want_rd;
      ncyc = 0; nrd = 0; nwr = 0; bad = 0; zacc = 0; exp_idx = 0; frz_bad = 0;
      first_par = -1; last_rd = 16'h0000; want_rd = 1'b1;
      exp_cyc = 513;
`ifdef OAM_DMA_ALIGN_EN
      // HALT sees parity ~tb_par; ALIGN is needed when the cycle after HALT is odd.
      if (tb_par) exp_cyc = 514;
`endif
      b0 = b_halt;
      cyc(16'h4014, 1'b0, pg, 1'b0);
      chk("trig_rdy", s_rdy, 1'b0);
      chk("trig_sel", s_sel, 1'b0);
      for (int n = 0; n < 600 && !s_rdy; n++) begin
         ncyc++;
         if (s_sel && (s_addr == 16'h0000)) zacc++;
         if (!s_sel && !s_rnw) bad++;
         if (s_sel && s_rnw) begin
            if (!want_rd || s_addr != {pg, 8'(exp_idx)}) bad++;
            if (first_par < 0) first_par = int'(tb_par);
            last_rd = s_addr;
            nrd++;
            want_rd = 1'b0;
            if (exp_idx == frz_idx) begin
               snap = {s_rdy, s_sel, s_addr, s_rnw, s_data, s_act};
               repeat (10) begin
                  @(negedge i_clk);
                  a_if.i_cpu_ce = 1'b0;
                  if ({a_if.o_cpu_rdy, a_if.o_bus_sel, a_if.o_bus_addr, a_if.o_bus_rnw,
                       a_if.o_bus_data, a_if.o_dma_active} !== snap) frz_bad++;
               end
               chk("freeze_hold", frz_bad, 0);
            end
         end else if (s_sel) begin
            if (want_rd || s_addr != 16'h2004 || s_data != ramp({pg, 8'(exp_idx)})) bad++;
            nwr++;
            want_rd = 1'b1;
            if (exp_idx == rst_idx) begin
               cyc(16'h0000, 1'b1, 8'h00, 1'b1);
               chk("rst_rdy", s_rdy, 1'b1);
               chk("rst_sel", s_sel, 1'b0);
               chk("rst_act", s_act, 1'b0);
               chk("rst_rnw", s_rnw, 1'b1);
               chk("rst_bad", bad, 0);
               return;
            end
            exp_idx++;
         end
         cyc(16'h0000, 1'b1, 8'h00, 1'b0);
      end
      chk("cycles", ncyc, exp_cyc);
      chk("reads", nrd, 256);
      chk("writes", nwr, 256);
      chk("seq_bad", bad, 0);
      chk("last_rd", last_rd, {pg, 8'hFF});
      chk("zero_acc", zacc, (pg == 8'h00) ? 1 : 0);
      chk("end_sel", s_sel, 1'b0);
      chk("end_act", s_act, 1'b0);
      chk("loop_cycles", b_halt - b0, exp_cyc);
`ifdef OAM_DMA_ALIGN_EN
      chk("first_rd_par", first_par, 0);
`endif
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = ramp(16'(i));
      a_if.i_cpu_ce   = 1'b0;
      a_if.i_cpu_addr = 16'h0000;
      a_if.i_cpu_rnw  = 1'b1;
      a_if.i_cpu_data = 8'h00;
      i_rst = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst  = 1'b0;
      tb_par = 1'b0;
      sample();
      chk("rst_rdy0", s_rdy, 1'b1);
      chk("rst_sel0", s_sel, 1'b0);
      chk("rst_addr0", s_addr, 16'h0000);
      chk("rst_rnw0", s_rnw, 1'b1);
      chk("rst_data0", s_data, 8'h00);
      chk("rst_act0", s_act, 1'b0);

      // Read of the trigger and write to its neighbour must not start a copy.
      cyc(16'h4014, 1'b1, 8'h02, 1'b0);
      chk("rd_trig_rdy", s_rdy, 1'b1);
      chk("rd_trig_act", s_act, 1'b0);
      cyc(16'h4015, 1'b0, 8'h02, 1'b0);
      chk("wr_4015_rdy", s_rdy, 1'b1);
      chk("wr_4015_sel", s_sel, 1'b0);

      if (tb_par) cyc(16'h0000, 1'b1, 8'h00, 1'b0);
      run_dma(8'h02, -1, -1);
      if (!tb_par) cyc(16'h0000, 1'b1, 8'h00, 1'b0);
      run_dma(8'h35, -1, 16);
      run_dma(8'hFF, -1, -1);
      run_dma(8'h10, 8'h80, -1);
      run_dma(8'h03, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/oam_dma_engine.md
# oam_dma_engine

Bus initiator that performs a 256-byte page copy on the CPU bus. A CPU write to the trigger register halts the CPU and starts the copy. The engine then drives read cycles from `page<<8 | idx` and write cycles to a fixed destination register. It sits beside the CPU in front of the bus control unit: while `o_bus_sel`=1 the top level muxes `o_bus_*` onto the bus in place of the CPU, and the engine consumes the bus control unit's multiplexed read data.

## Interface
- `TRIG_ADDR`, 16'h4014, CPU write address that starts a transfer.
- `DEST_ADDR`, 16'h2004, destination address written for every byte.
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_cpu_ce`  in  1  one-`i_clk` strobe marking the end of each CPU bus cycle; all engine state advances only on edges where it is 1.
- `i_cpu_addr`  in  16  CPU address; snooped for the trigger.
- `i_cpu_rnw`  in  1  CPU read/not-write.
- `i_cpu_data`  in  8  CPU write data; supplies the page number.
- `i_bus_data`  in  8  multiplexed read data returned to the bus initiator.
- `o_cpu_rdy`  out  1  0 halts the CPU.
- `o_bus_sel`  out  1  1 means the engine owns the bus.
- `o_bus_addr`  out  16  engine bus address.
- `o_bus_rnw`  out  1  engine read/not-write.
- `o_bus_data`  out  8  engine write data.
- `o_dma_active`  out  1  high from trigger acceptance until the last write cycle completes.

## Operation
- Registered state: `state`, `page[7:0]`, `idx[7:0]`, `latch[7:0]`, and the `parity` bit. `parity` toggles on every `i_cpu_ce`, including while the engine is idle.
- States and transitions:
  - IDLE → HALT when `i_cpu_ce` && !`i_cpu_rnw` && `i_cpu_addr`==`TRIG_ADDR`. On that edge: `page`←`i_cpu_data`, `idx`←0.
  - HALT: one dummy bus cycle in which the CPU is stalled and the bus is idle. HALT → ALIGN if the cycle after HALT has `parity`=1; otherwise HALT → READ.
  - ALIGN: one idle cycle, then → READ.
  - READ: `o_bus_addr`={`page`,`idx`}, `o_bus_rnw`=1. On the closing `i_cpu_ce`, `latch`←`i_bus_data`, then → WRITE.
  - WRITE: `o_bus_addr`=`DEST_ADDR`, `o_bus_rnw`=0, `o_bus_data`=`latch`. On the closing `i_cpu_ce`: if `idx`==8'hFF → IDLE, else `idx`←`idx`+1 and → READ.
- `o_cpu_rdy`=0 and `o_dma_active`=1 in every state except IDLE.
- `o_bus_sel`=1 only in READ and WRITE. In HALT and ALIGN, `o_bus_sel`=0, `o_bus_rnw`=1 and `o_bus_addr` holds its previous value.
- `idx` is 8 bits. The source never crosses a page; `page`=8'hFF reads $FF00-$FFFF.
- Source addresses are not restricted. Reads from MMIO ranges go out on the bus as normal read cycles, and any read side effects are the peripheral's responsibility.
- Trigger writes seen while not in IDLE are ignored, including the engine's own writes if `DEST_ADDR`==`TRIG_ADDR`.
- A CPU read of `TRIG_ADDR` never triggers.

## Timing
- Reset values: IDLE, `o_cpu_rdy`=1, `o_bus_sel`=0, `o_bus_addr`=16'h0000, `o_bus_rnw`=1, `o_bus_data`=8'h00, `o_dma_active`=0, `parity`=0, `idx`=0, `page`=0, `latch`=0.
- All outputs are registered and change only on edges with `i_cpu_ce`=1, so they are stable for a whole bus cycle.
- `i_rst` overrides `i_cpu_ce`. Reset mid-transfer returns to IDLE on the next edge and releases the CPU (`o_cpu_rdy`=1) immediately. There is no partial-completion flag.
- Latency, trigger acceptance to `o_cpu_rdy`=1: 513 bus cycles, or 514 when ALIGN is inserted. Breakdown: 1 HALT + (0|1) ALIGN + 512 READ/WRITE cycles.
- If `i_cpu_ce` is held low, the engine freezes in its current state with outputs held.
- The final WRITE and the return to IDLE (`o_cpu_rdy`→1, `o_bus_sel`→0) happen on the same edge, so the CPU's next cycle is the first cycle after the last write.

## Configuration
- `OAM_DMA_ALIGN_EN` defined: parity alignment is compiled in. ALIGN is inserted when needed, so every READ starts on `parity`=0 and the transfer takes 513 or 514 cycles.
- `OAM_DMA_ALIGN_EN` undefined: the ALIGN state and the parity check are removed. The path is always HALT → READ and every transfer takes exactly 513 cycles. The `parity` register may be optimized away.

## Test plan
- Reset, then CPU writes 8'h02 to $4014 with `i_cpu_ce` every 4th clock. Required:
  - READ addresses $0200..$02FF, with WRITE to $2004 following each READ.
  - Written data equals a preloaded ramp.
  - `o_cpu_rdy`=0 for 513 or 514 `i_cpu_ce` strobes.
- With `OAM_DMA_ALIGN_EN` defined, trigger once at `parity` 0 and once at `parity` 1. Required: one case takes 513 cycles and the other 514, and the first READ always has `parity`=0. Undefined: both cases take 513.
- Trigger with `page`=8'hFF. Required: last READ address $FFFF, `idx` wraps, no access to $0000, return to IDLE.
- Assert `i_rst` during the WRITE for `idx`=8'h80. Required: next edge shows IDLE, `o_cpu_rdy`=1, `o_bus_sel`=0, `o_dma_active`=0. A fresh trigger afterwards completes normally.
- CPU read of $4014 and CPU write to $4015. Required: no trigger, `o_cpu_rdy` stays 1.
- Set `DEST_ADDR`=16'h4014. Required: the engine's own writes cause no retrigger and the total stays 513 or 514 cycles.
- Hold `i_cpu_ce` low for 10 clocks mid-READ. Required: outputs hold, and resuming completes the transfer with correct data.
